// File: rtl/heap_sort_seq.sv
// Frame collector + N-pass odd-even transposition sorter + drainer for signed words.
// Optional macro HEAPSORT_DESC_EN: swap on a<b so the frame drains largest first.
module heap_sort_seq #(
  parameter int N = 6,
  parameter int W = 32
) (
  input  logic         system1000,
  input  logic         system1000_rstn,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic         busy
);

  localparam int CW = $clog2(N+1);

  typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;

  state_t          state;
  logic [N*W-1:0]  vec;
  logic [N*W-1:0]  pass_vec;
  logic [CW-1:0]   cnt;
  logic            last_cnt;

  assign last_cnt = (cnt == CW'(N-1));
  assign out_data = vec[W-1:0];

  // One transposition pass; pass parity (cnt[0]) selects even or odd pairs.
  always_comb begin
    pass_vec = vec;
    for (int k = 0; k < N-1; k++) begin
      if (k[0] == cnt[0]) begin
`ifdef HEAPSORT_DESC_EN
        if ($signed(vec[k*W +: W]) < $signed(vec[(k+1)*W +: W])) begin
`else
        if ($signed(vec[k*W +: W]) > $signed(vec[(k+1)*W +: W])) begin
`endif
          pass_vec[k*W +: W]     = vec[(k+1)*W +: W];
          pass_vec[(k+1)*W +: W] = vec[k*W +: W];
        end
      end
    end
  end

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      state     <= LOAD;
      vec       <= '0;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (in_valid && in_ready) begin
            vec <= {vec[(N-1)*W-1:0], in_data};
            if (last_cnt) begin
              cnt      <= '0;
              state    <= SORT;
              in_ready <= 1'b0;
              busy     <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        SORT: begin
          vec <= pass_vec;
          if (last_cnt) begin
            cnt       <= '0;
            state     <= DRAIN;
            out_valid <= 1'b1;
            out_last  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            vec <= {{W{1'b0}}, vec[N*W-1:W]};
            if (last_cnt) begin
              cnt       <= '0;
              state     <= LOAD;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
              in_ready  <= 1'b1;
            end else begin
              cnt      <= cnt + 1'b1;
              // out_last is registered, so it is set as cnt steps onto N-1.
              out_last <= (cnt == CW'(N-2));
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_heap_sort_seq.sv
// Directed bench for heap_sort_seq: ordering, latency, backpressure, gaps, mid-sort reset.
module tb_heap_sort_seq;

  logic        system1000;
  logic        system1000_rstn;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [31:0] expv [6];

  heap_sort_seq #(.N(6), .W(32)) dut (
    .system1000      (system1000),
    .system1000_rstn (system1000_rstn),
    .in_data         (in_data),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .out_data        (out_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_last        (out_last),
    .busy            (busy)
  );

  initial begin
    system1000 = 1'b0;
    forever #5 system1000 = ~system1000;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge system1000);
    #1;
  endtask

  task automatic send(input logic [31:0] v, input int gap);
    int w;
    w = 0;
    in_data  = v;
    in_valid = 1'b1;
    while (!in_ready && w < 50) begin
      tick();
      w++;
    end
    if (w >= 50) chk("send_ready_timeout", {31'b0, in_ready}, 32'd1);
    tick();
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) tick();
    end
  endtask

  // Counts edges from the last input handshake to out_valid; checks SORT-phase flags.
  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    chk({tag, "_sort_busy"}, {31'b0, busy}, 32'd1);
    while (!out_valid && n < 40) begin
      chk({tag, "_sort_in_ready"}, {31'b0, in_ready}, 32'd0);
      tick();
      n++;
    end
    chk({tag, "_latency"}, n, 32'd6);
  endtask

  task automatic drain(input string tag, input bit bp);
    int idx;
    int cyc;
    idx = 0;
    cyc = 0;
    while (idx < 6 && cyc < 100) begin
      out_ready = bp ? (cyc % 3 == 0) : 1'b1;
      chk({tag, "_out_valid"}, {31'b0, out_valid}, 32'd1);
      chk({tag, "_out_data"}, out_data, expv[idx]);
      chk({tag, "_out_last"}, {31'b0, out_last}, {31'b0, idx == 5});
      chk({tag, "_drain_in_ready"}, {31'b0, in_ready}, 32'd0);
      chk({tag, "_drain_busy"}, {31'b0, busy}, 32'd1);
      tick();
      if (out_ready) idx++;
      cyc++;
    end
    if (cyc >= 100) chk({tag, "_drain_timeout"}, idx, 32'd6);
    out_ready = 1'b1;
    chk({tag, "_end_in_ready"}, {31'b0, in_ready}, 32'd1);
    chk({tag, "_end_out_valid"}, {31'b0, out_valid}, 32'd0);
    chk({tag, "_end_busy"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    system1000_rstn = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;

    // Reset values
    #12;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_last", {31'b0, out_last}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    system1000_rstn = 1'b1;
    tick();

    // Frame A, back-to-back input, no backpressure
    send(32'd5, 0);
    send(-32'sd3, 0);
    send(32'd100, 0);
    send(32'd0, 0);
    send(32'd7, 0);
    send(-32'sd3, 0);
    in_valid = 1'b0;
`ifdef HEAPSORT_DESC_EN
    expv = '{32'd100, 32'd7, 32'd5, 32'd0, 32'hFFFFFFFD, 32'hFFFFFFFD};
`else
    expv = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'd0, 32'd5, 32'd7, 32'd100};
`endif
    wait_valid("a");
    drain("a", 1'b0);

    // Extremes with input gaps; in_valid held high with junk during SORT/DRAIN
    send(32'h7FFFFFFF, 2);
    send(32'h80000000, 2);
    send(32'hFFFFFFFF, 2);
    send(32'd1, 2);
    send(32'd0, 2);
    send(32'd2, 0);
    in_valid = 1'b1;
    in_data  = 32'h55555555;
`ifdef HEAPSORT_DESC_EN
    expv = '{32'h7FFFFFFF, 32'd2, 32'd1, 32'd0, 32'hFFFFFFFF, 32'h80000000};
`else
    expv = '{32'h80000000, 32'hFFFFFFFF, 32'd0, 32'd1, 32'd2, 32'h7FFFFFFF};
`endif
    wait_valid("ext");
    drain("ext", 1'b1);
    in_valid = 1'b0;

    // Aborted frame: reset during the third SORT cycle
    send(32'd90, 0);
    send(32'd80, 0);
    send(32'd70, 0);
    send(32'd60, 0);
    send(32'd50, 0);
    send(32'd40, 0);
    in_valid = 1'b0;
    tick();
    tick();
    system1000_rstn = 1'b0;
    #1;
    chk("mrst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("mrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("mrst_out_data", out_data, 32'd0);
    chk("mrst_out_last", {31'b0, out_last}, 32'd0);
    chk("mrst_busy", {31'b0, busy}, 32'd0);
    tick();
    tick();
    chk("mrst_hold_out_valid", {31'b0, out_valid}, 32'd0);
    chk("mrst_hold_busy", {31'b0, busy}, 32'd0);
    system1000_rstn = 1'b1;
    tick();
    chk("mrst_post_out_valid", {31'b0, out_valid}, 32'd0);

    send(32'd6, 0);
    send(32'd5, 0);
    send(32'd4, 0);
    send(32'd3, 0);
    send(32'd2, 0);
    send(32'd1, 0);
    in_valid = 1'b0;
`ifdef HEAPSORT_DESC_EN
    expv = '{32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
`else
    expv = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6};
`endif
    wait_valid("post");
    drain("post", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
